// File: rtl/dev_bus_arbiter_if.sv
// rtl/dev_bus_arbiter_if.sv - two-master request/ack and device bus bundle for dev_bus_arbiter
interface dev_bus_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wd;
    logic        m0_ack;
    logic [31:0] m0_rd;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wd;
    logic        m1_ack;
    logic [31:0] m1_rd;

    logic [31:0] bus_addr;
    logic [31:0] bus_wd;
    logic        bus_we;
    logic [31:0] bus_rd;

    logic        busy;
    logic        gnt;

    // Arbiter side: takes requests and bridge read data, drives acks and the bus
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wd,
        input  m1_req, m1_we, m1_addr, m1_wd,
        input  bus_rd,
        output m0_ack, m0_rd, m1_ack, m1_rd,
        output bus_addr, bus_wd, bus_we,
        output busy, gnt
    );

    // Requester/bridge side: the mirror image
    modport master (
        output m0_req, m0_we, m0_addr, m0_wd,
        output m1_req, m1_we, m1_addr, m1_wd,
        output bus_rd,
        input  m0_ack, m0_rd, m1_ack, m1_rd,
        input  bus_addr, bus_wd, bus_we,
        input  busy, gnt
    );
endinterface

// File: rtl/dev_bus_arbiter.sv
// rtl/dev_bus_arbiter.sv - two-master device bus arbiter/sequencer; ARB_FIXED_PRI_EN selects fixed m0 priority
module dev_bus_arbiter #(
    parameter int WAIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    dev_bus_arbiter_if.slave dbus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic        win;
    logic        any_req;
    logic        busy_q;
    logic        gnt_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wd_q;
    logic        m0_ack_q;
    logic        m1_ack_q;
    logic [31:0] m0_rd_q;
    logic [31:0] m1_rd_q;

    assign any_req = dbus.m0_req | dbus.m1_req;

`ifdef ARB_FIXED_PRI_EN
    // Fixed priority: master 1 only wins when the CPU is not asking
    always_comb begin
        win = !dbus.m0_req;
    end
`else
    logic ptr;

    // Round-robin: on contention the master that did not own the last access wins
    always_comb begin
        if (dbus.m0_req && dbus.m1_req) begin
            win = !ptr;
        end else begin
            win = !dbus.m0_req;
        end
    end

    // Last-owner pointer, reset to 1 so the CPU takes the first contention
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b1;
        end else if (state == IDLE && any_req) begin
            ptr <= win;
        end
    end
`endif

    // Access sequencer: latch the winner, hold the bus for WAIT+1 cycles, pulse ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            lat_we     <= 1'b0;
            busy_q     <= 1'b0;
            gnt_q      <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= 32'd0;
            bus_wd_q   <= 32'd0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rd_q    <= 32'd0;
            m1_rd_q    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= ACC;
                        cnt        <= WAIT_CNT;
                        busy_q     <= 1'b1;
                        gnt_q      <= win;
                        lat_we     <= win ? dbus.m1_we   : dbus.m0_we;
                        bus_we_q   <= win ? dbus.m1_we   : dbus.m0_we;
                        bus_addr_q <= win ? dbus.m1_addr : dbus.m0_addr;
                        bus_wd_q   <= win ? dbus.m1_wd   : dbus.m0_wd;
                    end
                end
                ACC: begin
                    // Devices must see exactly one write strobe per access
                    bus_we_q <= 1'b0;
                    if (cnt == 4'd0) begin
                        state      <= DONE;
                        bus_addr_q <= 32'd0;
                        bus_wd_q   <= 32'd0;
                        if (!lat_we) begin
                            if (gnt_q) begin
                                m1_rd_q <= dbus.bus_rd;
                            end else begin
                                m0_rd_q <= dbus.bus_rd;
                            end
                        end
                        if (gnt_q) begin
                            m1_ack_q <= 1'b1;
                        end else begin
                            m0_ack_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy_q   <= 1'b0;
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbus.busy     = busy_q;
    assign dbus.gnt      = gnt_q;
    assign dbus.bus_we   = bus_we_q;
    assign dbus.bus_addr = bus_addr_q;
    assign dbus.bus_wd   = bus_wd_q;
    assign dbus.m0_ack   = m0_ack_q;
    assign dbus.m1_ack   = m1_ack_q;
    assign dbus.m0_rd    = m0_rd_q;
    assign dbus.m1_rd    = m1_rd_q;
endmodule
